// File: rtl/gvp_pkg.sv
// Shared constants, FSM state type and helpers for the GVP store packer.
package gvp_pkg;

    localparam logic [15:0] FRAME_MARKER_DEF = 16'hA5C3;
    localparam logic [1:0]  FT_DATA          = 2'd1;
    localparam logic [1:0]  FT_HDR           = 2'd2;
    localparam int unsigned HDR_LEN          = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_W0,
        ST_BODY
    } gvp_state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] m);
        logic [4:0] c;
        c = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            c = c + 5'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gvp_mask_scan.sv
// Walks a captured source mask lowest-bit first, clearing one bit per advance.
module gvp_mask_scan (
    input  logic        a_clk,
    input  logic        a_resetn,
    input  logic        load,
    input  logic [15:0] load_mask,
    input  logic        advance,
    output logic [3:0]  sel_idx,
    output logic        done,
    output logic        last
);

    logic [15:0] mask_q;
    logic        found;

    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (mask_q[i] && !found) begin
                sel_idx = 4'(i);
                found   = 1'b1;
            end
        end
    end

    assign done = (mask_q == '0);
    // exactly one bit left: the word about to be emitted is the final one
    assign last = !done && ((mask_q & (mask_q - 16'd1)) == '0);

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            mask_q <= '0;
        end else if (load) begin
            mask_q <= load_mask;
        end else if (advance && !done) begin
            mask_q <= mask_q & (mask_q - 16'd1);
        end
    end

endmodule

// File: rtl/gvp_store_packer.sv
// Snapshots GVP state on a store trigger and emits it as one framed AXI-Stream packet.
module gvp_store_packer
    import gvp_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 16,
    parameter int unsigned SRC_MASK_LSB = 16,
    parameter logic [15:0] FRAME_MARKER = FRAME_MARKER_DEF
) (
    input  logic                   a_clk,
    input  logic                   a_resetn,
    input  logic                   enable,
    input  logic [1:0]             store_data,
    input  logic [31:0]            index,
    input  logic [31:0]            options,
    input  logic [47:0]            gvp_time,
    input  logic [31:0]            gvp_x,
    input  logic [31:0]            gvp_y,
    input  logic [31:0]            gvp_z,
    input  logic [31:0]            gvp_u,
    input  logic [NUM_SRC*32-1:0]  src_data,
    output logic [31:0]            M_AXIS_tdata,
    output logic                   M_AXIS_tvalid,
    input  logic                   M_AXIS_tready,
    output logic                   M_AXIS_tlast,
    output logic                   busy,
    output logic [15:0]            overrun_count
);

    localparam int unsigned SRC_W = 16 * 32;

    gvp_state_e state_q, state_d;

    logic [1:0]       store_q;
    logic [31:0]      index_q;
    logic             trig, hs, capture, drop;
    logic             scan_adv, scan_done, scan_last;
    logic [3:0]       sel_idx, word_q, word_d, word_nx;
    logic [31:0]      tdata_d, w0_word;
    logic             tvalid_d, tlast_d;
    logic [15:0]      mask_in;
    logic [SRC_W-1:0] src_ext;

    logic [1:0]  snap_type;
    logic [31:0] snap_index, snap_options, snap_x, snap_y, snap_z, snap_u;
    logic [47:0] snap_time;
    logic [31:0] snap_src [16];

    assign mask_in = 16'(options[SRC_MASK_LSB +: NUM_SRC]);
    assign src_ext = SRC_W'(src_data);
    assign hs      = M_AXIS_tvalid && M_AXIS_tready;
    assign word_nx = word_q + 4'd1;
    assign busy    = (state_q != ST_IDLE);

    // store_data is a level from the core; a repeated point shows up only as an index change
    assign trig = enable && (store_data == FT_DATA || store_data == FT_HDR)
                  && (store_data != store_q || index != index_q);

    always_comb begin
        if (store_data == FT_HDR) begin
            w0_word = {FRAME_MARKER, 8'(HDR_LEN), 8'(FT_HDR)};
        end else begin
            w0_word = {FRAME_MARKER, 8'(popcount16(mask_in)) + 8'd2, 8'(FT_DATA)};
        end
    end

    gvp_mask_scan u_scan (
        .a_clk     (a_clk),
        .a_resetn  (a_resetn),
        .load      (capture),
        .load_mask ((store_data == FT_DATA) ? mask_in : 16'd0),
        .advance   (scan_adv),
        .sel_idx   (sel_idx),
        .done      (scan_done),
        .last      (scan_last)
    );

    always_comb begin
        state_d  = state_q;
        tdata_d  = M_AXIS_tdata;
        tvalid_d = M_AXIS_tvalid;
        tlast_d  = M_AXIS_tlast;
        word_d   = word_q;
        scan_adv = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: capture = trig;
            ST_W0: begin
                if (hs) begin
                    state_d = ST_BODY;
                    word_d  = 4'd1;
                    if (snap_type == FT_HDR) begin
                        tdata_d = snap_index;
                        tlast_d = 1'b0;
                    end else begin
                        tdata_d = snap_time[31:0];
                        tlast_d = scan_done;
                    end
                end
            end
            ST_BODY: begin
                if (hs) begin
                    if (M_AXIS_tlast) begin
                        // a trigger landing on the final handshake starts the next frame with no gap
                        capture  = trig;
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = '0;
                    end else if (snap_type == FT_HDR) begin
                        word_d  = word_nx;
                        tlast_d = (word_nx == 4'(HDR_LEN - 1));
                        case (word_nx)
                            4'd2:    tdata_d = snap_options;
                            4'd3:    tdata_d = {16'd0, snap_time[47:32]};
                            4'd4:    tdata_d = snap_time[31:0];
                            4'd5:    tdata_d = snap_x;
                            4'd6:    tdata_d = snap_y;
                            4'd7:    tdata_d = snap_z;
                            default: tdata_d = snap_u;
                        endcase
                    end else begin
                        tdata_d  = snap_src[sel_idx];
                        tlast_d  = scan_last;
                        scan_adv = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            state_d  = ST_W0;
            tdata_d  = w0_word;
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
            word_d   = '0;
        end
    end

    assign drop = trig && !capture;

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q       <= ST_IDLE;
            store_q       <= '0;
            index_q       <= '0;
            word_q        <= '0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tlast  <= 1'b0;
            overrun_count <= '0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_data;
            index_q       <= index;
            word_q        <= word_d;
            M_AXIS_tdata  <= tdata_d;
            M_AXIS_tvalid <= tvalid_d;
            M_AXIS_tlast  <= tlast_d;
            if (drop && overrun_count != '1) begin
                overrun_count <= overrun_count + 16'd1;
            end
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            snap_type    <= '0;
            snap_index   <= '0;
            snap_options <= '0;
            snap_time    <= '0;
            snap_x       <= '0;
            snap_y       <= '0;
            snap_z       <= '0;
            snap_u       <= '0;
            for (int unsigned k = 0; k < 16; k++) begin
                snap_src[k] <= '0;
            end
        end else if (capture) begin
            snap_type    <= store_data;
            snap_index   <= index;
            snap_options <= options;
            snap_time    <= gvp_time;
            snap_x       <= gvp_x;
            snap_y       <= gvp_y;
            snap_z       <= gvp_z;
            snap_u       <= gvp_u;
            for (int unsigned k = 0; k < 16; k++) begin
                snap_src[k] <= src_ext[k*32 +: 32];
            end
        end
    end

endmodule

// File: tb/tb_gvp_store_packer.sv
// Directed bench for gvp_store_packer with hand-computed frame contents.
module tb_gvp_store_packer;

    logic          a_clk = 1'b0;
    logic          a_resetn;
    logic          enable;
    logic [1:0]    store_data;
    logic [31:0]   index;
    logic [31:0]   options;
    logic [47:0]   gvp_time;
    logic [31:0]   gvp_x, gvp_y, gvp_z, gvp_u;
    logic [511:0]  src_data;
    logic [31:0]   M_AXIS_tdata;
    logic          M_AXIS_tvalid;
    logic          M_AXIS_tready;
    logic          M_AXIS_tlast;
    logic          busy;
    logic [15:0]   overrun_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_w [32];
    logic        got_l [32];
    logic [31:0] exp_w [32];
    int          got_n;
    logic        timed_out;

    always #5 a_clk = ~a_clk;

    gvp_store_packer #(
        .NUM_SRC      (16),
        .SRC_MASK_LSB (16),
        .FRAME_MARKER (16'hA5C3)
    ) dut (
        .a_clk         (a_clk),
        .a_resetn      (a_resetn),
        .enable        (enable),
        .store_data    (store_data),
        .index         (index),
        .options       (options),
        .gvp_time      (gvp_time),
        .gvp_x         (gvp_x),
        .gvp_y         (gvp_y),
        .gvp_z         (gvp_z),
        .gvp_u         (gvp_u),
        .src_data      (src_data),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    task automatic step();
        @(posedge a_clk);
        #1;
    endtask

    // records every handshaken word until tlast, then moves one cycle past it
    task automatic collect(input int max_cyc);
        got_n     = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 32; i++) begin
            got_w[i] = '0;
            got_l[i] = 1'b0;
        end
        for (int c = 0; c < max_cyc && timed_out; c++) begin
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                if (got_n < 32) begin
                    got_w[got_n] = M_AXIS_tdata;
                    got_l[got_n] = M_AXIS_tlast;
                end
                got_n++;
                if (M_AXIS_tlast) timed_out = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset();
        a_resetn = 1'b0; enable = 1'b1; store_data = 2'd0; index = '0; options = '0;
        gvp_time = '0; gvp_x = '0; gvp_y = '0; gvp_z = '0; gvp_u = '0; src_data = '0;
        M_AXIS_tready = 1'b1;
        step(); step();
        a_resetn = 1'b1;
        step();
        total++; if (M_AXIS_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", M_AXIS_tvalid); end
        total++; if (M_AXIS_tdata !== 32'd0) begin bad++; $display("FAIL rst_tdata got=%h exp=0", M_AXIS_tdata); end
        total++; if (M_AXIS_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b exp=0", M_AXIS_tlast); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (overrun_count !== 16'd0) begin bad++; $display("FAIL rst_overrun got=%h exp=0", overrun_count); end
    endtask

    task automatic test_header();
        index = 32'd5; options = 32'h0003_0001; gvp_time = 48'h0001_0000_0010;
        gvp_x = 32'd1; gvp_y = 32'd2; gvp_z = 32'd3; gvp_u = 32'd4;
        M_AXIS_tready = 1'b1;
        store_data = 2'd2;
        total++; if (M_AXIS_tvalid !== 1'b0) begin bad++; $display("FAIL hdr_pre_tvalid got=%b exp=0", M_AXIS_tvalid); end
        step();
        total++; if (M_AXIS_tvalid !== 1'b1) begin bad++; $display("FAIL hdr_latency got=%b exp=1", M_AXIS_tvalid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hdr_busy got=%b exp=1", busy); end
        gvp_x = 32'hDEAD_0001; gvp_y = 32'hDEAD_0002; gvp_time = 48'hFFFF_FFFF_FFFF;
        exp_w[0] = 32'hA5C3_0902; exp_w[1] = 32'd5; exp_w[2] = 32'h0003_0001;
        exp_w[3] = 32'h0000_0001; exp_w[4] = 32'h0000_0010;
        exp_w[5] = 32'd1; exp_w[6] = 32'd2; exp_w[7] = 32'd3; exp_w[8] = 32'd4;
        collect(20);
        total++; if (timed_out !== 1'b0 || got_n !== 9) begin bad++; $display("FAIL hdr_len got=%0d exp=9", got_n); end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 8)) begin
                bad++; $display("FAIL hdr_w%0d got=%h/%b exp=%h/%b", i, got_w[i], got_l[i], exp_w[i], (i == 8));
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hdr_idle got=%b exp=0", busy); end
        store_data = 2'd0;
        step();
    endtask

    task automatic test_data();
        index = 32'd6; options = 32'h0005_0000; gvp_time = 48'h0000_1234_5678;
        src_data = '0;
        src_data[0*32 +: 32] = 32'hAA; src_data[1*32 +: 32] = 32'hBB; src_data[2*32 +: 32] = 32'hCC;
        store_data = 2'd1;
        step();
        src_data[2*32 +: 32] = 32'h0BAD;
        exp_w[0] = 32'hA5C3_0401; exp_w[1] = 32'h1234_5678; exp_w[2] = 32'hAA; exp_w[3] = 32'hCC;
        collect(20);
        total++; if (timed_out !== 1'b0 || got_n !== 4) begin bad++; $display("FAIL data_len got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 3)) begin
                bad++; $display("FAIL data_w%0d got=%h/%b exp=%h/%b", i, got_w[i], got_l[i], exp_w[i], (i == 3));
            end
        end
    endtask

    task automatic test_backpressure();
        logic        hold_chk;
        logic [31:0] hold_d;
        logic        fin;
        int          n;
        src_data[0*32 +: 32] = 32'h11; src_data[2*32 +: 32] = 32'h22;
        gvp_time = 48'h0000_0BAD_F00D;
        index = 32'd7;
        step();
        exp_w[0] = 32'hA5C3_0401; exp_w[1] = 32'h0BAD_F00D; exp_w[2] = 32'h11; exp_w[3] = 32'h22;
        hold_chk = 1'b0; hold_d = '0; fin = 1'b0; n = 0;
        for (int i = 0; i < 32; i++) begin got_w[i] = '0; got_l[i] = 1'b0; end
        for (int c = 0; c < 40 && !fin; c++) begin
            M_AXIS_tready = (c % 2 == 1);
            if (hold_chk) begin
                total++;
                if (M_AXIS_tdata !== hold_d || M_AXIS_tvalid !== 1'b1) begin
                    bad++; $display("FAIL bp_stable got=%h/%b exp=%h/1", M_AXIS_tdata, M_AXIS_tvalid, hold_d);
                end
            end
            hold_chk = M_AXIS_tvalid && !M_AXIS_tready;
            hold_d   = M_AXIS_tdata;
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                if (n < 32) begin got_w[n] = M_AXIS_tdata; got_l[n] = M_AXIS_tlast; end
                n++;
                if (M_AXIS_tlast) fin = 1'b1;
            end
            step();
        end
        M_AXIS_tready = 1'b1;
        total++; if (fin !== 1'b1 || n !== 4) begin bad++; $display("FAIL bp_len got=%0d exp=4", n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 3)) begin
                bad++; $display("FAIL bp_w%0d got=%h/%b exp=%h/%b", i, got_w[i], got_l[i], exp_w[i], (i == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        M_AXIS_tready = 1'b1;
        options = 32'h0000_0000; gvp_time = 48'h0000_0000_0A0A; index = 32'd30;
        step();
        total++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'hA5C3_0201) begin
            bad++; $display("FAIL b2b_w0a got=%h/%b exp=a5c30201/1", M_AXIS_tdata, M_AXIS_tvalid); end
        step();
        total++; if (M_AXIS_tdata !== 32'h0000_0A0A || M_AXIS_tlast !== 1'b1) begin
            bad++; $display("FAIL b2b_w1a got=%h/%b exp=00000a0a/1", M_AXIS_tdata, M_AXIS_tlast); end
        index = 32'd31; options = 32'h0005_0000; gvp_time = 48'h0000_0000_0B0B;
        src_data[0*32 +: 32] = 32'h5A; src_data[2*32 +: 32] = 32'h5C;
        step();
        total++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'hA5C3_0401 || M_AXIS_tlast !== 1'b0) begin
            bad++; $display("FAIL b2b_w0b got=%h/%b/%b exp=a5c30401/1/0", M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast); end
        total++; if (overrun_count !== 16'd0) begin bad++; $display("FAIL b2b_overrun got=%h exp=0", overrun_count); end
        exp_w[0] = 32'hA5C3_0401; exp_w[1] = 32'h0000_0B0B; exp_w[2] = 32'h5A; exp_w[3] = 32'h5C;
        collect(20);
        total++; if (timed_out !== 1'b0 || got_n !== 4) begin bad++; $display("FAIL b2b_len got=%0d exp=4", got_n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 3)) begin
                bad++; $display("FAIL b2b_w%0d got=%h/%b exp=%h/%b", i, got_w[i], got_l[i], exp_w[i], (i == 3));
            end
        end
        total++; if (busy !== 1'b0 || overrun_count !== 16'd0) begin
            bad++; $display("FAIL b2b_end got=%b/%h exp=0/0000", busy, overrun_count); end
    endtask

    task automatic test_enable_reserved();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin index = 32'd32 + 32'(i); step(); end
        step();
        total++; if (busy !== 1'b0 || M_AXIS_tvalid !== 1'b0 || overrun_count !== 16'd0) begin
            bad++; $display("FAIL en_low got=%b/%b/%h exp=0/0/0000", busy, M_AXIS_tvalid, overrun_count); end
        enable = 1'b1; store_data = 2'd3;
        for (int i = 0; i < 3; i++) begin index = 32'd35 + 32'(i); step(); end
        step();
        total++; if (busy !== 1'b0 || overrun_count !== 16'd0) begin
            bad++; $display("FAIL sd3_ignored got=%b/%h exp=0/0000", busy, overrun_count); end
    endtask

    task automatic test_overrun();
        M_AXIS_tready = 1'b0;
        options = 32'hFFFF_0000; gvp_time = 48'h0000_0000_0777;
        for (int k = 0; k < 16; k++) src_data[k*32 +: 32] = 32'h100 + 32'(k);
        store_data = 2'd1; index = 32'd10;
        step();
        for (int i = 0; i < 3; i++) begin index = 32'd11 + 32'(i); step(); end
        step();
        total++; if (overrun_count !== 16'd3) begin bad++; $display("FAIL ovr_count got=%h exp=0003", overrun_count); end
        total++; if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'hA5C3_1201) begin
            bad++; $display("FAIL ovr_hold_w0 got=%h/%b exp=a5c31201/1", M_AXIS_tdata, M_AXIS_tvalid); end
        M_AXIS_tready = 1'b1;
        exp_w[0] = 32'hA5C3_1201; exp_w[1] = 32'h0000_0777;
        for (int k = 0; k < 16; k++) exp_w[k+2] = 32'h100 + 32'(k);
        collect(40);
        total++; if (timed_out !== 1'b0 || got_n !== 18) begin bad++; $display("FAIL ovr_len got=%0d exp=18", got_n); end
        for (int i = 0; i < 18; i++) begin
            total++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 17)) begin
                bad++; $display("FAIL ovr_w%0d got=%h/%b exp=%h/%b", i, got_w[i], got_l[i], exp_w[i], (i == 17));
            end
        end
        total++; if (overrun_count !== 16'd3) begin bad++; $display("FAIL ovr_after got=%h exp=0003", overrun_count); end
    endtask

    task automatic test_saturation();
        M_AXIS_tready = 1'b0;
        index = 32'd20;
        step();
        for (int i = 0; i < 66000; i++) begin
            index = (i % 2 == 0) ? 32'd21 : 32'd22;
            step();
        end
        step();
        total++; if (overrun_count !== 16'hFFFF) begin bad++; $display("FAIL sat_count got=%h exp=ffff", overrun_count); end
        M_AXIS_tready = 1'b1;
        collect(40);
        total++; if (timed_out !== 1'b0 || got_n !== 18 || got_w[0] !== 32'hA5C3_1201) begin
            bad++; $display("FAIL sat_drain got=%0d/%h exp=18/a5c31201", got_n, got_w[0]); end
    endtask

    task automatic test_reset_mid();
        M_AXIS_tready = 1'b1;
        options = 32'h0000_00FF; gvp_time = 48'h0002_0000_0003;
        gvp_x = 32'd9; gvp_y = 32'd8; gvp_z = 32'd7; gvp_u = 32'd6;
        index = 32'd50; store_data = 2'd2;
        step();
        step(); step(); step();
        total++; if (M_AXIS_tdata !== 32'h0000_0002 || M_AXIS_tvalid !== 1'b1) begin
            bad++; $display("FAIL rmid_w3 got=%h/%b exp=00000002/1", M_AXIS_tdata, M_AXIS_tvalid); end
        #2;
        a_resetn = 1'b0; store_data = 2'd0;
        #1;
        total++; if (M_AXIS_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_async got=%b exp=0", M_AXIS_tvalid); end
        #2;
        a_resetn = 1'b1;
        step();
        total++; if (busy !== 1'b0 || overrun_count !== 16'd0 || M_AXIS_tvalid !== 1'b0) begin
            bad++; $display("FAIL rmid_after got=%b/%h/%b exp=0/0000/0", busy, overrun_count, M_AXIS_tvalid); end
        index = 32'd51; store_data = 2'd2;
        step();
        exp_w[0] = 32'hA5C3_0902; exp_w[1] = 32'd51; exp_w[2] = 32'h0000_00FF;
        exp_w[3] = 32'h0000_0002; exp_w[4] = 32'h0000_0003;
        exp_w[5] = 32'd9; exp_w[6] = 32'd8; exp_w[7] = 32'd7; exp_w[8] = 32'd6;
        collect(20);
        total++; if (timed_out !== 1'b0 || got_n !== 9) begin bad++; $display("FAIL rmid_len got=%0d exp=9", got_n); end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 8)) begin
                bad++; $display("FAIL rmid_w%0d got=%h/%b exp=%h/%b", i, got_w[i], got_l[i], exp_w[i], (i == 8));
            end
        end
    endtask

    initial begin
        test_reset();
        test_header();
        test_data();
        test_backpressure();
        test_back_to_back();
        test_enable_reserved();
        test_overrun();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
